// File: rtl/dot_product_udiv_71ns_32ns_39_seq_if.sv
// Start/done handshake bundle for the sequential unsigned divider: operands, clock enable and results.
interface dot_product_udiv_71ns_32ns_39_seq_if #(
   parameter int din0_WIDTH = 71,
   parameter int din1_WIDTH = 32,
   parameter int dout_WIDTH = 39
);
   logic                  ce;
   logic                  start;
   logic [din0_WIDTH-1:0] din0;
   logic [din1_WIDTH-1:0] din1;
   logic                  ready;
   logic                  done;
   logic [dout_WIDTH-1:0] dout;
   logic [din1_WIDTH-1:0] rem;
   logic                  ovf;
   logic                  dbz;

   modport master (
      output ce, start, din0, din1,
      input  ready, done, dout, rem, ovf, dbz
   );

   modport slave (
      input  ce, start, din0, din1,
      output ready, done, dout, rem, ovf, dbz
   );
endinterface

// File: rtl/dot_product_udiv_71ns_32ns_39_seq.sv
// Restoring unsigned divider: one quotient bit per enabled cycle, MSB first, recovering the
// cofactor of the 32x39 multiplier together with remainder, overflow and divide-by-zero flags.
module dot_product_udiv_71ns_32ns_39_seq #(
   parameter int ID         = 1,
   parameter int din0_WIDTH = 71,
   parameter int din1_WIDTH = 32,
   parameter int dout_WIDTH = 39
) (
   input logic clk,
   input logic reset,
   dot_product_udiv_71ns_32ns_39_seq_if.slave bus
);
   localparam int N  = din0_WIDTH;
   localparam int W  = din1_WIDTH;
   localparam int CW = $clog2(N + 1);

   // The overflow slice needs at least one quotient bit above the output width.
   if (dout_WIDTH >= din0_WIDTH || ID < 0) begin : g_badParams
      $error("dot_product_udiv: dout_WIDTH must be below din0_WIDTH and ID non-negative");
   end

   typedef enum logic {IDLE, BUSY} state_t;

   state_t                state_q;
   logic [N-1:0]          shiftReg_q;
   logic [W-1:0]          divisor_q;
   logic [W-1:0]          partialRem_q;
   logic [CW-1:0]         count_q;
   logic                  done_q;
   logic [dout_WIDTH-1:0] dout_q;
   logic [W-1:0]          rem_q;
   logic                  ovf_q;
   logic                  dbz_q;

   logic [W:0]            remShift;
   logic                  quotBit;
   logic [W-1:0]          partialRem_d;
   logic [N-1:0]          shiftReg_d;

   // Dividend bits leave the top of shiftReg while quotient bits enter the bottom, so after
   // N steps the register holds the full quotient. A zero divisor naturally yields all ones.
   always_comb begin
      remShift     = {partialRem_q, shiftReg_q[N-1]};
      quotBit      = (remShift >= {1'b0, divisor_q});
      partialRem_d = quotBit ? (remShift[W-1:0] - divisor_q) : remShift[W-1:0];
      shiftReg_d   = {shiftReg_q[N-2:0], quotBit};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         shiftReg_q   <= '0;
         divisor_q    <= '0;
         partialRem_q <= '0;
         count_q      <= '0;
         done_q       <= 1'b0;
         dout_q       <= '0;
         rem_q        <= '0;
         ovf_q        <= 1'b0;
         dbz_q        <= 1'b0;
      end else if (bus.ce) begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  shiftReg_q   <= bus.din0;
                  divisor_q    <= bus.din1;
                  partialRem_q <= '0;
                  count_q      <= '0;
                  state_q      <= BUSY;
               end
            end
            BUSY: begin
               shiftReg_q   <= shiftReg_d;
               partialRem_q <= partialRem_d;
               count_q      <= count_q + 1'b1;
               if (count_q == CW'(N - 1)) begin
                  state_q <= IDLE;
                  done_q  <= 1'b1;
                  dout_q  <= shiftReg_d[dout_WIDTH-1:0];
                  rem_q   <= partialRem_d;
                  ovf_q   <= (divisor_q != '0) && (|shiftReg_d[N-1:dout_WIDTH]);
                  dbz_q   <= (divisor_q == '0);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.ready = (state_q == IDLE);
   assign bus.done  = done_q;
   assign bus.dout  = dout_q;
   assign bus.rem   = rem_q;
   assign bus.ovf   = ovf_q;
   assign bus.dbz   = dbz_q;
endmodule
